// File: rtl/i2c_reg_slave.sv
// I2C register-file slave: synchronized SCL/SDA, 7-bit addressing, auto-incrementing
// register pointer, MSB-first bytes, open-drain SDA drive and a write-strobe side port.
module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h22,
  parameter int         NUM_REGS       = 16,
  parameter int         I2C_DATA_WIDTH = 8,
  localparam int        AW             = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
  output logic                      wr_strobe_o,
  output logic [AW-1:0]             wr_addr_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      busy_o
);

  localparam int DW = I2C_DATA_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      scl_sync_q, sda_sync_q;
  logic            scl_prev_q, sda_prev_q;
  logic [3:0]      cnt_q, cnt_d;
  logic [DW-1:0]   sh_q, sh_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            sda_q, sda_d;
  logic            busy_q, busy_d;
  logic            strobe_q, reg_we;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [DW-1:0]   regs_q [NUM_REGS];

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [DW-1:0] rd_byte;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SCL must be stable high across both samples so an SCL edge is never mistaken for START/STOP.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rd_byte   = regs_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    sda_d     = sda_q;
    busy_d    = busy_q;
    reg_we    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start_det) begin
      state_d = S_ADDR;
      cnt_d   = 4'd0;
      sda_d   = 1'b1;
    end else if (stop_det) begin
      state_d = S_IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            sh_d  = {sh_q[DW-2:0], sda_s};
            cnt_d = cnt_q + 4'd1;
            if (state_q == S_WDATA && cnt_q == 4'd7) begin
              reg_we    = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = {sh_q[DW-2:0], sda_s};
              ptr_d     = ptr_q + AW'(1);
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_d = 1'b0;
            if (state_q == S_ADDR) begin
              if (sh_q[7:1] == SLAVE_ADDR) begin
                state_d = S_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = S_IGNORE;
                sda_d   = 1'b1;
                busy_d  = 1'b0;
              end
            end else if (state_q == S_PTR) begin
              state_d = S_PTR_ACK;
              ptr_d   = sh_q[AW-1:0];
            end else begin
              state_d = S_WDATA_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            sda_d = 1'b1;
            state_d = S_PTR;
            if (sh_q[0]) begin
              state_d = S_RDATA;
              sh_d    = rd_byte;
              sda_d   = rd_byte[DW-1];
              cnt_d   = 4'd1;
            end
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            state_d = S_WDATA;
            sda_d   = 1'b1;
            cnt_d   = 4'd0;
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = S_RDATA_ACK;
              sda_d   = 1'b1;
              ptr_d   = ptr_q + AW'(1);
            end else begin
              sda_d = sh_q[DW-2];
              sh_d  = {sh_q[DW-2:0], 1'b0};
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        S_RDATA_ACK: begin
          // A fall here always follows an ACKed 9th rise; a NACK has already left the state.
          if (scl_rise && sda_s) begin
            state_d = S_IGNORE;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            state_d = S_RDATA;
            sh_d    = rd_byte;
            sda_d   = rd_byte[DW-1];
            cnt_d   = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      cnt_q      <= 4'd0;
      sh_q       <= '0;
      ptr_q      <= '0;
      sda_q      <= 1'b1;
      busy_q     <= 1'b0;
      strobe_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      ptr_q      <= ptr_d;
      sda_q      <= sda_d;
      busy_q     <= busy_d;
      strobe_q   <= reg_we;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      if (reg_we) regs_q[ptr_q] <= wr_data_d;
    end
  end

  assign sda_o       = sda_q;
  assign wr_strobe_o = strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged I2C master on an open-drain bus,
// write-strobe log checked against an expected queue of (addr, data) pairs.
module tb_i2c_reg_slave;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       sda_o, wr_strobe_o, busy_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       sda_bus;

  int total = 0;
  int bad   = 0;

  logic [11:0] got_q[$];
  logic [11:0] exp_q[$];
  int          sda_low_cnt = 0;
  int          busy_cnt    = 0;

  assign sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_reg_slave dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
    .sda_o       (sda_o),
    .wr_strobe_o (wr_strobe_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .busy_o      (busy_o)
  );

  always @(negedge clk) begin
    if (wr_strobe_o) got_q.push_back({wr_addr_o, wr_data_o});
    if (!sda_o) sda_low_cnt++;
    if (busy_o) busy_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
    end
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; wait_clk(Q);
      scl_m = 1'b1; wait_clk(2 * Q);
      scl_m = 1'b0; wait_clk(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    ack = sda_bus; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      b[i] = sda_bus; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
    end
    sda_m = ack_bit; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
    sda_m = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(3);
    total++; if (sda_o !== 1'b1)       begin bad++; $display("FAIL reset_sda got=%b exp=1", sda_o); end
    total++; if (wr_strobe_o !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", wr_strobe_o); end
    total++; if (wr_addr_o !== 4'd0)   begin bad++; $display("FAIL reset_addr got=%h exp=0", wr_addr_o); end
    total++; if (wr_data_o !== 8'h00)  begin bad++; $display("FAIL reset_data got=%h exp=00", wr_data_o); end
    total++; if (busy_o !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_write();
    logic ack;
    int   base;
    logic [11:0] obs;
    base = got_q.size();
    exp_q.delete();
    exp_q.push_back({4'd3, 8'hA5});
    exp_q.push_back({4'd4, 8'h5A});
    i2c_start();
    send_byte(8'h44, ack);
    total++; if (ack !== 1'b0)    begin bad++; $display("FAIL write_addr_ack got=%b exp=0", ack); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL write_busy got=%b exp=1", busy_o); end
    send_byte(8'h03, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL write_ptr_ack got=%b exp=0", ack); end
    send_byte(8'hA5, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL write_d0_ack got=%b exp=0", ack); end
    send_byte(8'h5A, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL write_d1_ack got=%b exp=0", ack); end
    i2c_stop();
    wait_clk(Q);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL write_busy_after_stop got=%b exp=0", busy_o); end
    total++; if (got_q.size() - base !== exp_q.size()) begin bad++; $display("FAIL write_strobe_count got=%0d exp=%0d", got_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (base + i < got_q.size()) ? got_q[base + i] : 12'hxxx;
      total++; if (obs !== exp_q[i]) begin bad++; $display("FAIL write_strobe_%0d got=%h exp=%h", i, obs, exp_q[i]); end
    end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] b;
    int base;
    base = got_q.size();
    i2c_start();
    send_byte(8'h44, ack);
    send_byte(8'h03, ack);
    i2c_start();
    send_byte(8'h45, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL read_addr_ack got=%b exp=0", ack); end
    read_byte(1'b0, b);
    total++; if (b !== 8'hA5) begin bad++; $display("FAIL read_byte0 got=%h exp=a5", b); end
    read_byte(1'b1, b);
    total++; if (b !== 8'h5A) begin bad++; $display("FAIL read_byte1 got=%h exp=5a", b); end
    wait_clk(Q);
    total++; if (sda_o !== 1'b1)  begin bad++; $display("FAIL read_sda_after_nack got=%b exp=1", sda_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL read_busy_after_nack got=%b exp=0", busy_o); end
    i2c_stop();
    total++; if (got_q.size() !== base) begin bad++; $display("FAIL read_no_strobe got=%0d exp=%0d", got_q.size(), base); end
  endtask

  task automatic test_wrap();
    logic ack;
    logic [7:0] b;
    int base;
    logic [11:0] obs;
    base = got_q.size();
    exp_q.delete();
    exp_q.push_back({4'd15, 8'h11});
    exp_q.push_back({4'd0, 8'h22});
    i2c_start();
    send_byte(8'h44, ack);
    send_byte(8'h0F, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL wrap_d1_ack got=%b exp=0", ack); end
    i2c_stop();
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (base + i < got_q.size()) ? got_q[base + i] : 12'hxxx;
      total++; if (obs !== exp_q[i]) begin bad++; $display("FAIL wrap_strobe_%0d got=%h exp=%h", i, obs, exp_q[i]); end
    end
    i2c_start();
    send_byte(8'h44, ack);
    send_byte(8'h0F, ack);
    i2c_start();
    send_byte(8'h45, ack);
    read_byte(1'b0, b);
    total++; if (b !== 8'h11) begin bad++; $display("FAIL wrap_reg15 got=%h exp=11", b); end
    read_byte(1'b1, b);
    total++; if (b !== 8'h22) begin bad++; $display("FAIL wrap_reg0 got=%h exp=22", b); end
    i2c_stop();
  endtask

  task automatic test_wrong_addr();
    logic ack;
    int base, low0, busy0;
    base = got_q.size(); low0 = sda_low_cnt; busy0 = busy_cnt;
    i2c_start();
    send_byte(8'h46, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL wrong_addr_ack got=%b exp=1", ack); end
    send_byte(8'hFF, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL wrong_data_ack got=%b exp=1", ack); end
    i2c_stop();
    total++; if (sda_low_cnt !== low0) begin bad++; $display("FAIL wrong_sda_low got=%0d exp=%0d", sda_low_cnt - low0, 0); end
    total++; if (busy_cnt !== busy0)   begin bad++; $display("FAIL wrong_busy got=%0d exp=%0d", busy_cnt - busy0, 0); end
    total++; if (got_q.size() !== base) begin bad++; $display("FAIL wrong_strobe got=%0d exp=%0d", got_q.size(), base); end
  endtask

  task automatic test_ptr_stop();
    logic ack;
    logic [7:0] b;
    int base;
    base = got_q.size();
    i2c_start();
    send_byte(8'h44, ack);
    send_byte(8'h03, ack);
    i2c_stop();
    i2c_start();
    send_byte(8'h45, ack);
    read_byte(1'b1, b);
    total++; if (b !== 8'hA5) begin bad++; $display("FAIL ptr_stop_read got=%h exp=a5", b); end
    i2c_stop();
    total++; if (got_q.size() !== base) begin bad++; $display("FAIL ptr_stop_strobe got=%0d exp=%0d", got_q.size(), base); end
  endtask

  task automatic test_abort();
    logic ack;
    logic [7:0] b;
    int base;
    base = got_q.size();
    i2c_start();
    send_byte(8'h44, ack);
    send_byte(8'h04, ack);
    send_bits(8'hFF, 4);
    i2c_start();
    send_byte(8'h45, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL abort_addr_ack got=%b exp=0", ack); end
    read_byte(1'b1, b);
    total++; if (b !== 8'h5A) begin bad++; $display("FAIL abort_read got=%h exp=5a", b); end
    i2c_stop();
    total++; if (got_q.size() !== base) begin bad++; $display("FAIL abort_strobe got=%0d exp=%0d", got_q.size(), base); end
  endtask

  task automatic test_reset_mid();
    logic ack;
    logic [7:0] b;
    i2c_start();
    send_byte(8'h44, ack);
    send_byte(8'h00, ack);
    i2c_start();
    send_byte(8'h45, ack);
    sda_m = 1'b1;
    wait_clk(Q);
    total++; if (sda_o !== 1'b0) begin bad++; $display("FAIL midrst_bit7_low got=%b exp=0", sda_o); end
    scl_m = 1'b1;
    wait_clk(2);
    #3 rst_n = 1'b0;
    #1;
    total++; if (sda_o !== 1'b1)  begin bad++; $display("FAIL midrst_sda_release got=%b exp=1", sda_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    i2c_start();
    send_byte(8'h45, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL midrst_addr_ack got=%b exp=0", ack); end
    read_byte(1'b1, b);
    total++; if (b !== 8'h00) begin bad++; $display("FAIL midrst_reg0 got=%h exp=00", b); end
    i2c_stop();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_wrong_addr();
    test_ptr_stop();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
